// File: rtl/r_window_counter.sv
// Kernel-row (R) window counter for the conv-layer address generators.
// Sequences R 0..LONG_TERM with an optional per-mode early wrap.
//
// Ports:
//   clk       clock, all state on rising edge
//   rst       asynchronous active-high reset
//   mode      layer mode, sampled only at pass start
//   l_zero    L counter at zero strobe
//   j_zero    J counter at zero strobe
//   k_zero    K counter at zero strobe
//   stall     freeze all state this cycle
//   r         current R value
//   r_zero    current cycle is a wrap cycle (comb)
//   long_done 1-cycle pulse after a LONG_TERM wrap
//   served    served-mode register
//   mode_err  1-cycle pulse: start trigger with an illegal mode
module r_window_counter #(
    parameter int R_W        = 3,
    parameter int MODE_W     = 3,
    parameter int NUM_MODES  = 6,
    parameter int LONG_TERM  = 5,
    parameter logic [R_W*NUM_MODES-1:0] SHORT_TERM =
        {3'd1, 3'd0, 3'd2, 3'd1, 3'd1, 3'd1},
    parameter logic [NUM_MODES-1:0] JWAIT_MASK   = 6'b011000,
    parameter logic [NUM_MODES-1:0] ALWAYS_SHORT = 6'b000010,
    parameter logic [MODE_W*NUM_MODES-1:0] NEXT_TABLE =
        {3'd0, 3'd5, 3'd4, 3'd3, 3'd2, 3'd2}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [MODE_W-1:0] mode,
    input  logic              l_zero,
    input  logic              j_zero,
    input  logic              k_zero,
    input  logic              stall,
    output logic [R_W-1:0]    r,
    output logic              r_zero,
    output logic              long_done,
    output logic [MODE_W-1:0] served,
    output logic              mode_err
);

    localparam logic [R_W-1:0]  LONG_R = R_W'(LONG_TERM);
    localparam logic [MODE_W:0] NUM_M  = (MODE_W+1)'(NUM_MODES);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [R_W-1:0]    r_q;
    logic [MODE_W-1:0] mode_q;
    logic [MODE_W-1:0] served_q;
    logic              long_done_q;
    logic              mode_err_q;

    logic              mode_ok;
    logic              jw;
    logic              trig;
    logic [R_W-1:0]    sh_term;
    logic              alw;
    logic [MODE_W-1:0] nxt;
    logic              short_hit;
    logic              long_hit;
    logic              wrap;

    // Illegal modes get no JWAIT bit; they can still raise a trigger
    // so that mode_err is reported.
    assign mode_ok = {1'b0, mode} < NUM_M;

    always_comb begin
        jw = 1'b0;
        for (int i = 0; i < NUM_MODES; i++) begin
            if (mode == MODE_W'(i)) begin
                jw = JWAIT_MASK[i];
            end
        end
    end

    always_comb begin
        sh_term = '0;
        alw     = 1'b0;
        nxt     = '0;
        for (int i = 0; i < NUM_MODES; i++) begin
            if (mode_q == MODE_W'(i)) begin
                sh_term = SHORT_TERM[i*R_W +: R_W];
                alw     = ALWAYS_SHORT[i];
                nxt     = NEXT_TABLE[i*MODE_W +: MODE_W];
            end
        end
    end

    assign trig = k_zero | (l_zero & j_zero) | (l_zero & ~jw);

    // Once the latched mode has been served its short pass is skipped,
    // unless the mode is flagged to always take the short wrap.
    assign short_hit = (sh_term != '0) & (r_q == sh_term) &
                       ((served_q != mode_q) | alw);
    assign long_hit  = (r_q == LONG_R);
    assign wrap      = long_hit | short_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (~stall & trig & mode_ok) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (~stall & wrap) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        r_zero = (state_q == RUN) & wrap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q         <= '0;
            mode_q      <= '0;
            served_q    <= '0;
            long_done_q <= 1'b0;
            mode_err_q  <= 1'b0;
        end else begin
            long_done_q <= 1'b0;
            mode_err_q  <= 1'b0;
            if (~stall) begin
                if (state_q == IDLE) begin
                    if (trig & mode_ok) begin
                        mode_q <= mode;
                        r_q    <= R_W'(1);
                    end else if (trig) begin
                        mode_err_q <= 1'b1;
                    end
                end else if (wrap) begin
                    r_q <= '0;
                    if (long_hit) begin
                        served_q    <= nxt;
                        long_done_q <= 1'b1;
                    end
                end else begin
                    r_q <= r_q + R_W'(1);
                end
            end
        end
    end

    assign r         = r_q;
    assign long_done = long_done_q;
    assign served    = served_q;
    assign mode_err  = mode_err_q;

endmodule
